// File: rtl/mlp_conv_axi_burst_slave_if.sv
// rtl/mlp_conv_axi_burst_slave_if.sv - AXI4 burst channel bundle between the conv DMA master and the loopback slave
interface mlp_conv_axi_burst_slave_if #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32
);
    logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
    logic [7:0]                        S_AXI_AWLEN;
    logic [2:0]                        S_AXI_AWSIZE;
    logic [1:0]                        S_AXI_AWBURST;
    logic                              S_AXI_AWVALID;
    logic                              S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
    logic                              S_AXI_WLAST;
    logic                              S_AXI_WVALID;
    logic                              S_AXI_WREADY;
    logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID;
    logic [1:0]                        S_AXI_BRESP;
    logic                              S_AXI_BVALID;
    logic                              S_AXI_BREADY;
    logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
    logic [7:0]                        S_AXI_ARLEN;
    logic [2:0]                        S_AXI_ARSIZE;
    logic [1:0]                        S_AXI_ARBURST;
    logic                              S_AXI_ARVALID;
    logic                              S_AXI_ARREADY;
    logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                        S_AXI_RRESP;
    logic                              S_AXI_RLAST;
    logic                              S_AXI_RVALID;
    logic                              S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/mlp_conv_axi_burst_slave.sv
// rtl/mlp_conv_axi_burst_slave.sv - AXI4 burst responder backed by a word-addressed memory
module mlp_conv_axi_burst_slave #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_MEM_DEPTH        = 64
) (
    input  logic S_AXI_ACLK,
    input  logic S_AXI_ARESET,
    mlp_conv_axi_burst_slave_if.slave s_axi
);
    localparam int IDX_W  = $clog2(C_MEM_DEPTH);
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [C_S_AXI_ID_WIDTH-1:0] id_t;
    typedef logic [C_S_AXI_DATA_WIDTH-1:0] data_t;

    // Only 32-bit beats with INCR or FIXED stepping are served; anything else is answered with SLVERR
    function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'b010) || burst[1];
    endfunction

    data_t mem [C_MEM_DEPTH];

    w_state_e w_state_q, w_state_d;
    logic     awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0] bresp_q, bresp_d;
    id_t      bid_q, bid_d, w_id_q, w_id_d;
    idx_t     w_idx_q, w_idx_d;
    logic [7:0] w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic     w_err_q, w_err_d, w_fixed_q, w_fixed_d;
    logic     w_last_beat, mem_we;

    r_state_e r_state_q, r_state_d;
    logic     arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    data_t    rdata_q, rdata_d;
    logic [1:0] rresp_q, rresp_d;
    id_t      rid_q, rid_d;
    idx_t     r_idx_q, r_idx_d, r_next_idx;
    logic [7:0] r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic     r_err_q, r_err_d, r_fixed_q, r_fixed_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:IDX_W+2],
                                s_axi.S_AXI_ARADDR[1:0], s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:IDX_W+2]};

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_BID     = bid_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RLAST   = rlast_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign s_axi.S_AXI_RID     = rid_q;

    // Write FSM next state: accept AW, absorb beats until the counter reaches AWLEN, then respond on B
    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        bid_d     = bid_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        w_fixed_d = w_fixed_q;
        mem_we    = 1'b0;
        w_last_beat = (w_cnt_q == w_len_q);
        case (w_state_q)
            W_IDLE: begin
                if (s_axi.S_AXI_AWVALID && awready_q) begin
                    w_id_d    = s_axi.S_AXI_AWID;
                    w_idx_d   = s_axi.S_AXI_AWADDR[IDX_W+1:2];
                    w_len_d   = s_axi.S_AXI_AWLEN;
                    w_cnt_d   = 8'd0;
                    w_err_d   = burst_err(s_axi.S_AXI_AWSIZE, s_axi.S_AXI_AWBURST);
                    w_fixed_d = (s_axi.S_AXI_AWBURST == 2'b00);
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi.S_AXI_WVALID && wready_q) begin
                    mem_we = !w_err_q;
                    // A WLAST that disagrees with the beat count poisons the response but not the beat count
                    if (s_axi.S_AXI_WLAST != w_last_beat) begin
                        w_err_d = 1'b1;
                    end
                    if (w_last_beat) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bid_d     = w_id_q;
                        bresp_d   = w_err_d ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d = w_cnt_q + 8'd1;
                        if (!w_fixed_q) begin
                            w_idx_d = w_idx_q + idx_t'(1);
                        end
                    end
                end
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                    bid_d     = '0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM registers
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_len_q   <= 8'd0;
            w_cnt_q   <= 8'd0;
            w_err_q   <= 1'b0;
            w_fixed_q <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            w_fixed_q <= w_fixed_d;
        end
    end

    // Byte-enabled memory write; contents survive reset, but a beat coinciding with reset is dropped
    always_ff @(posedge S_AXI_ACLK) begin
        if (mem_we && !S_AXI_ARESET) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi.S_AXI_WSTRB[b]) begin
                    mem[w_idx_q][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    // Read FSM next state: memory is sampled at the handshake edge, so a same-cycle write is not seen
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rid_d     = rid_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_err_d   = r_err_q;
        r_fixed_d = r_fixed_q;
        r_next_idx = r_fixed_q ? r_idx_q : r_idx_q + idx_t'(1);
        case (r_state_q)
            R_IDLE: begin
                if (s_axi.S_AXI_ARVALID && arready_q) begin
                    r_idx_d   = s_axi.S_AXI_ARADDR[IDX_W+1:2];
                    r_len_d   = s_axi.S_AXI_ARLEN;
                    r_cnt_d   = 8'd0;
                    r_err_d   = burst_err(s_axi.S_AXI_ARSIZE, s_axi.S_AXI_ARBURST);
                    r_fixed_d = (s_axi.S_AXI_ARBURST == 2'b00);
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rid_d     = s_axi.S_AXI_ARID;
                    rlast_d   = (s_axi.S_AXI_ARLEN == 8'd0);
                    rresp_d   = r_err_d ? RESP_SLVERR : RESP_OKAY;
                    rdata_d   = r_err_d ? '0 : mem[r_idx_d];
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && s_axi.S_AXI_RREADY) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rdata_d   = '0;
                        rresp_d   = RESP_OKAY;
                        rid_d     = '0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d = r_next_idx;
                        r_cnt_d = r_cnt_q + 8'd1;
                        rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
                        rdata_d = r_err_q ? '0 : mem[r_next_idx];
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM registers
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= '0;
            r_idx_q   <= '0;
            r_len_q   <= 8'd0;
            r_cnt_q   <= 8'd0;
            r_err_q   <= 1'b0;
            r_fixed_q <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rid_q     <= rid_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_err_q   <= r_err_d;
            r_fixed_q <= r_fixed_d;
        end
    end
endmodule

// File: tb/tb_mlp_conv_axi_burst_slave.sv
// tb/tb_mlp_conv_axi_burst_slave.sv - self-checking bench for the AXI4 burst loopback slave
module tb_mlp_conv_axi_burst_slave;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mlp_conv_axi_burst_slave_if #(.C_S_AXI_ID_WIDTH(1), .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32)) axi ();

    mlp_conv_axi_burst_slave #(
        .C_S_AXI_ID_WIDTH(1), .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32), .C_MEM_DEPTH(DEPTH)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESET(rst),
        .s_axi(axi)
    );

    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic id; } rexp_t;
    typedef struct { logic id; logic [1:0] resp; } bexp_t;
    typedef struct {
        logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
        logic [31:0] base; int early; logic [1:0] bresp; logic readback;
    } wvec_t;

    rexp_t exp_r_q[$];
    bexp_t exp_b_q[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] wdat [256];
    logic [3:0]  wstb [256];
    wvec_t vecs [6];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic check_reset(input string n);
        check({n, "_awready"}, 32'(axi.S_AXI_AWREADY), 32'd1);
        check({n, "_arready"}, 32'(axi.S_AXI_ARREADY), 32'd1);
        check({n, "_wready"},  32'(axi.S_AXI_WREADY),  32'd0);
        check({n, "_bvalid"},  32'(axi.S_AXI_BVALID),  32'd0);
        check({n, "_rvalid"},  32'(axi.S_AXI_RVALID),  32'd0);
        check({n, "_rlast"},   32'(axi.S_AXI_RLAST),   32'd0);
        check({n, "_bresp"},   32'(axi.S_AXI_BRESP),   32'd0);
        check({n, "_rresp"},   32'(axi.S_AXI_RRESP),   32'd0);
        check({n, "_rdata"},   axi.S_AXI_RDATA,        32'd0);
        check({n, "_bid"},     32'(axi.S_AXI_BID),     32'd0);
        check({n, "_rid"},     32'(axi.S_AXI_RID),     32'd0);
    endtask

    task automatic send_aw(input logic id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        logic hs = 1'b0;
        axi.S_AXI_AWID = id; axi.S_AXI_AWADDR = addr; axi.S_AXI_AWLEN = len;
        axi.S_AXI_AWSIZE = size; axi.S_AXI_AWBURST = burst; axi.S_AXI_AWVALID = 1'b1;
        while (!hs && n < 200) begin
            @(negedge clk); hs = axi.S_AXI_AWREADY;
            @(posedge clk); #1; n++;
        end
        axi.S_AXI_AWVALID = 1'b0;
        if (!hs) timeout("aw_handshake");
    endtask

    task automatic send_ar(input logic id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        logic hs = 1'b0;
        axi.S_AXI_ARID = id; axi.S_AXI_ARADDR = addr; axi.S_AXI_ARLEN = len;
        axi.S_AXI_ARSIZE = size; axi.S_AXI_ARBURST = burst; axi.S_AXI_ARVALID = 1'b1;
        while (!hs && n < 200) begin
            @(negedge clk); hs = axi.S_AXI_ARREADY;
            @(posedge clk); #1; n++;
        end
        axi.S_AXI_ARVALID = 1'b0;
        if (!hs) timeout("ar_handshake");
    endtask

    task automatic send_w(input logic [7:0] len, input int early, input logic gaps);
        for (int i = 0; i <= int'(len); i++) begin
            int n = 0;
            logic hs = 1'b0;
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    axi.S_AXI_WVALID = 1'b0;
                    @(posedge clk); #1;
                end
            end
            axi.S_AXI_WVALID = 1'b1;
            axi.S_AXI_WDATA  = wdat[i];
            axi.S_AXI_WSTRB  = wstb[i];
            axi.S_AXI_WLAST  = (early >= 0) ? (i == early) : (i == int'(len));
            while (!hs && n < 200) begin
                @(negedge clk); hs = axi.S_AXI_WREADY;
                @(posedge clk); #1; n++;
            end
            if (!hs) timeout("w_handshake");
        end
        axi.S_AXI_WVALID = 1'b0;
        axi.S_AXI_WLAST  = 1'b0;
    endtask

    task automatic recv_b(input string name);
        int n = 0;
        logic hs = 1'b0;
        bexp_t e;
        axi.S_AXI_BREADY = 1'b1;
        while (!hs && n < 200) begin
            @(negedge clk);
            if (axi.S_AXI_BVALID) begin
                hs = 1'b1;
                if (exp_b_q.size() == 0) timeout({name, "_b_scoreboard_empty"});
                else begin
                    e = exp_b_q.pop_front();
                    check({name, "_bid"},   32'(axi.S_AXI_BID),   32'(e.id));
                    check({name, "_bresp"}, 32'(axi.S_AXI_BRESP), 32'(e.resp));
                end
            end
            @(posedge clk); #1; n++;
        end
        axi.S_AXI_BREADY = 1'b0;
        if (!hs) timeout({name, "_b"});
    endtask

    task automatic recv_r(input string name, input int beats, input logic rnd);
        int got = 0;
        int cyc = 0;
        logic rdy;
        rexp_t e;
        while (got < beats && cyc < 500) begin
            rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            axi.S_AXI_RREADY = rdy;
            @(negedge clk);
            if (axi.S_AXI_RVALID && rdy) begin
                if (exp_r_q.size() == 0) timeout({name, "_r_scoreboard_empty"});
                else begin
                    e = exp_r_q.pop_front();
                    check({name, "_rdata"}, axi.S_AXI_RDATA,        e.data);
                    check({name, "_rresp"}, 32'(axi.S_AXI_RRESP),   32'(e.resp));
                    check({name, "_rlast"}, 32'(axi.S_AXI_RLAST),   32'(e.last));
                    check({name, "_rid"},   32'(axi.S_AXI_RID),     32'(e.id));
                end
                got++;
            end
            @(posedge clk); #1; cyc++;
        end
        axi.S_AXI_RREADY = 1'b0;
        if (got < beats) timeout({name, "_r"});
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int base = int'(addr[31:2]) % DEPTH;
        for (int i = 0; i <= int'(len); i++) begin
            int idx = (burst == 2'b00) ? base : (base + i) % DEPTH;
            for (int b = 0; b < 4; b++) begin
                if (wstb[i][b]) model_mem[idx][8*b +: 8] = wdat[i][8*b +: 8];
            end
        end
    endtask

    task automatic push_reads(input logic id, input logic [31:0] addr, input logic [7:0] len);
        int base = int'(addr[31:2]) % DEPTH;
        for (int i = 0; i <= int'(len); i++) begin
            exp_r_q.push_back('{model_mem[(base + i) % DEPTH], 2'b00, (i == int'(len)), id});
        end
    endtask

    task automatic write_burst(input logic id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input int early,
                               input logic gaps, input logic [1:0] resp);
        exp_b_q.push_back('{id, resp});
        send_aw(id, addr, len, size, burst);
        send_w(len, early, gaps);
        recv_b("wr");
    endtask

    initial begin
        logic [3:0]  pat;
        logic        prev_stall, prev_last;
        logic [31:0] prev_data;
        int          hs_cnt, cyc;
        rexp_t       e;

        vecs[0] = '{32'h0000_0100, 8'd15, 3'd2, 2'b01, 32'h0000_0000, -1, 2'b00, 1'b1};
        vecs[1] = '{32'h0000_0010, 8'd0,  3'd2, 2'b01, 32'hAABB_CCDD, -1, 2'b00, 1'b1};
        vecs[2] = '{32'h0000_0100, 8'd0,  3'd1, 2'b01, 32'hDEAD_0000, -1, 2'b10, 1'b1};
        vecs[3] = '{32'h0000_0040, 8'd5,  3'd2, 2'b01, 32'h0000_5000,  2, 2'b10, 1'b0};
        vecs[4] = '{32'h0000_00F8, 8'd3,  3'd2, 2'b01, 32'h0000_F800, -1, 2'b00, 1'b1};
        vecs[5] = '{32'h0000_0080, 8'd1,  3'd2, 2'b11, 32'h0000_7000, -1, 2'b10, 1'b0};

        axi.S_AXI_AWID = 1'b0; axi.S_AXI_AWADDR = 32'd0; axi.S_AXI_AWLEN = 8'd0;
        axi.S_AXI_AWSIZE = 3'd2; axi.S_AXI_AWBURST = 2'b01; axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WDATA = 32'd0; axi.S_AXI_WSTRB = 4'h0; axi.S_AXI_WLAST = 1'b0; axi.S_AXI_WVALID = 1'b0;
        axi.S_AXI_BREADY = 1'b0;
        axi.S_AXI_ARID = 1'b0; axi.S_AXI_ARADDR = 32'd0; axi.S_AXI_ARLEN = 8'd0;
        axi.S_AXI_ARSIZE = 3'd2; axi.S_AXI_ARBURST = 2'b01; axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven write bursts, each optionally read back against the model
        for (int i = 0; i < 6; i++) begin
            logic id = 1'(i + 1);
            for (int k = 0; k <= int'(vecs[i].len); k++) begin
                wdat[k] = vecs[i].base + 32'(k);
                wstb[k] = 4'hF;
            end
            write_burst(id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
                        vecs[i].early, 1'b1, vecs[i].bresp);
            if (vecs[i].bresp == 2'b00) model_write(vecs[i].addr, vecs[i].len, vecs[i].burst);
            if (vecs[i].readback) begin
                push_reads(id, vecs[i].addr, vecs[i].len);
                send_ar(id, vecs[i].addr, vecs[i].len, 3'd2, 2'b01);
                recv_r("vec_rd", int'(vecs[i].len) + 1, 1'(i % 2));
            end
        end

        // FIXED burst with partial strobes merges into word 4
        wdat[0] = 32'h1111_1111; wstb[0] = 4'h1;
        wdat[1] = 32'h2222_2222; wstb[1] = 4'h8;
        write_burst(1'b0, 32'h10, 8'd1, 3'd2, 2'b00, -1, 1'b0, 2'b00);
        model_write(32'h10, 8'd1, 2'b00);
        exp_r_q.push_back('{32'h22BB_CC11, 2'b00, 1'b1, 1'b0});
        send_ar(1'b0, 32'h10, 8'd0, 3'd2, 2'b01);
        recv_r("fixed_strb", 1, 1'b0);

        // Read backpressure with RREADY pattern 1,0,0,1
        push_reads(1'b0, 32'h100, 8'd3);
        send_ar(1'b0, 32'h100, 8'd3, 3'd2, 2'b01);
        pat = 4'b1001; hs_cnt = 0; cyc = 0; prev_stall = 1'b0; prev_data = 32'd0; prev_last = 1'b0;
        while (hs_cnt < 4 && cyc < 100) begin
            axi.S_AXI_RREADY = pat[cyc % 4];
            @(negedge clk);
            if (prev_stall) begin
                check("bp_hold_rdata", axi.S_AXI_RDATA, prev_data);
                check("bp_hold_rlast", 32'(axi.S_AXI_RLAST), 32'(prev_last));
            end
            prev_stall = axi.S_AXI_RVALID && !axi.S_AXI_RREADY;
            prev_data  = axi.S_AXI_RDATA;
            prev_last  = axi.S_AXI_RLAST;
            if (axi.S_AXI_RVALID && axi.S_AXI_RREADY) begin
                e = exp_r_q.pop_front();
                check("bp_rdata", axi.S_AXI_RDATA, e.data);
                check("bp_rlast", 32'(axi.S_AXI_RLAST), 32'(e.last));
                hs_cnt++;
            end
            @(posedge clk); #1; cyc++;
        end
        axi.S_AXI_RREADY = 1'b0;
        check("bp_handshakes", 32'(hs_cnt), 32'd4);
        @(negedge clk);
        check("bp_arready_after", 32'(axi.S_AXI_ARREADY), 32'd1);
        check("bp_rvalid_after", 32'(axi.S_AXI_RVALID), 32'd0);
        @(posedge clk); #1;

        // WRAP read is an error burst: zero data, SLVERR, RLAST on beat 2
        for (int k = 0; k < 3; k++) exp_r_q.push_back('{32'h0, 2'b10, (k == 2), 1'b1});
        send_ar(1'b1, 32'h100, 8'd2, 3'd2, 2'b10);
        recv_r("err_rd", 3, 1'b1);

        // Same-cycle read and write of word 0: read returns the value left by the wrapped burst
        wdat[0] = 32'h1234_5678; wstb[0] = 4'hF;
        exp_b_q.push_back('{1'b0, 2'b00});
        exp_r_q.push_back('{32'h0000_F802, 2'b00, 1'b1, 1'b0});
        send_aw(1'b0, 32'h0, 8'd0, 3'd2, 2'b01);
        axi.S_AXI_WVALID = 1'b1; axi.S_AXI_WDATA = wdat[0]; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WLAST = 1'b1;
        axi.S_AXI_ARID = 1'b0; axi.S_AXI_ARADDR = 32'h0; axi.S_AXI_ARLEN = 8'd0;
        axi.S_AXI_ARSIZE = 3'd2; axi.S_AXI_ARBURST = 2'b01; axi.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        check("conc_wready", 32'(axi.S_AXI_WREADY), 32'd1);
        check("conc_arready", 32'(axi.S_AXI_ARREADY), 32'd1);
        @(posedge clk); #1;
        axi.S_AXI_WVALID = 1'b0; axi.S_AXI_WLAST = 1'b0; axi.S_AXI_ARVALID = 1'b0;
        recv_r("conc_rd", 1, 1'b0);
        recv_b("conc_wr");
        model_mem[0] = 32'h1234_5678;
        push_reads(1'b0, 32'h0, 8'd0);
        send_ar(1'b0, 32'h0, 8'd0, 3'd2, 2'b01);
        recv_r("conc_after", 1, 1'b0);

        // Reset during beat 3 of concurrent 16-beat write and read
        for (int k = 0; k < 16; k++) begin wdat[k] = 32'h0000_A000 + 32'(k); wstb[k] = 4'hF; end
        axi.S_AXI_AWID = 1'b1; axi.S_AXI_AWADDR = 32'h180; axi.S_AXI_AWLEN = 8'd15;
        axi.S_AXI_AWSIZE = 3'd2; axi.S_AXI_AWBURST = 2'b01; axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_ARID = 1'b1; axi.S_AXI_ARADDR = 32'h100; axi.S_AXI_ARLEN = 8'd15;
        axi.S_AXI_ARSIZE = 3'd2; axi.S_AXI_ARBURST = 2'b01; axi.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        check("rst_aw_ready", 32'(axi.S_AXI_AWREADY), 32'd1);
        check("rst_ar_ready", 32'(axi.S_AXI_ARREADY), 32'd1);
        @(posedge clk); #1;
        axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_WVALID = 1'b1; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WLAST = 1'b0; axi.S_AXI_RREADY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            axi.S_AXI_WDATA = wdat[k];
            @(negedge clk);
            check("rst_beat_wready", 32'(axi.S_AXI_WREADY), 32'd1);
            check("rst_beat_rvalid", 32'(axi.S_AXI_RVALID), 32'd1);
            @(posedge clk); #1;
        end
        axi.S_AXI_WDATA = wdat[3];
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        axi.S_AXI_WVALID = 1'b0; axi.S_AXI_RREADY = 1'b0;
        check_reset("rst_mid");
        for (int k = 0; k < 3; k++) model_mem[32 + k] = wdat[k];
        push_reads(1'b0, 32'h180, 8'd2);
        send_ar(1'b0, 32'h180, 8'd2, 3'd2, 2'b01);
        recv_r("rst_persist", 3, 1'b0);

        for (int k = 0; k < 4; k++) begin wdat[k] = 32'h0000_B000 + 32'(k); wstb[k] = 4'hF; end
        write_burst(1'b1, 32'h180, 8'd3, 3'd2, 2'b01, -1, 1'b1, 2'b00);
        model_write(32'h180, 8'd3, 2'b01);
        push_reads(1'b1, 32'h180, 8'd3);
        send_ar(1'b1, 32'h180, 8'd3, 3'd2, 2'b01);
        recv_r("post_rst", 4, 1'b1);

        check("sb_r_empty", 32'(exp_r_q.size()), 32'd0);
        check("sb_b_empty", 32'(exp_b_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
